// File: rtl/instr_encode_pkg.sv
// Shared types for the RV32I encoder: format enum, NOP word and the decoded-fields struct.
// Opcode encodings mirror opcode.vh and are defined here only if it has not already been included.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef LUI
`define LUI   7'b0110111
`define AUIPC 7'b0010111
`define JAL   7'b1101111
`define JALR  7'b1100111
`define B     7'b1100011
`define LOAD  7'b0000011
`define STORE 7'b0100011
`define I     7'b0010011
`define R     7'b0110011
`endif

package instr_encode_pkg;

   typedef enum logic [2:0] {FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_R, FMT_BAD} fmt_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // Immediates are sign-extended to this width so one packer serves any XLEN up to 64.
   localparam int IMM_W = 64;

   typedef struct packed {
      logic [6:0]       opcode;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [IMM_W-1:0] imm;
   } fields_t;

   function automatic fmt_e fmt_of(input logic [6:0] op);
      fmt_e fmt;
      case (op)
         `LUI, `AUIPC:       fmt = FMT_U;
         `JAL:               fmt = FMT_J;
         `JALR, `LOAD, `I:   fmt = FMT_I;
         `STORE:             fmt = FMT_S;
         `B:                 fmt = FMT_B;
         `R:                 fmt = FMT_R;
         default:            fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded fields -> 32-bit instruction word plus error flag.
// IMM_CHECK_EN adds immediate range checking; without it immediates truncate silently.
module instr_pack
   import instr_encode_pkg::*;
(
   input  fields_t     f,
   output logic [31:0] instr,
   output logic        err
);

   fmt_e             fmt;
   logic             shift;
   logic             range_err;
   logic [IMM_W-1:0] imm;

   assign fmt   = fmt_of(f.opcode);
   assign imm   = f.imm;
   // SLLI/SRLI/SRAI carry funct7 in the upper bits and a 5-bit shamt.
   assign shift = (f.opcode == `I) && (f.funct3[1:0] == 2'b01);

   always_comb begin
      instr = NOP;
      case (fmt)
         FMT_U: instr = {imm[31:12], f.rd, f.opcode};
         FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
         FMT_I: instr = shift ? {f.funct7, imm[4:0], f.rs1, f.funct3, f.rd, f.opcode}
                              : {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
         FMT_S: instr = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode};
         FMT_B: instr = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode};
         FMT_R: instr = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
         default: instr = NOP;
      endcase
   end

`ifdef IMM_CHECK_EN
   always_comb begin
      range_err = 1'b0;
      case (fmt)
         FMT_U: range_err = (imm[11:0] != '0);
         FMT_J: range_err = (imm[IMM_W-1:20] != {(IMM_W-20){imm[20]}}) || imm[0];
         FMT_I: range_err = shift ? (imm[IMM_W-1:5] != '0)
                                  : (imm[IMM_W-1:11] != {(IMM_W-11){imm[11]}});
         FMT_S: range_err = (imm[IMM_W-1:11] != {(IMM_W-11){imm[11]}});
         FMT_B: range_err = (imm[IMM_W-1:12] != {(IMM_W-12){imm[12]}}) || imm[0];
         default: range_err = 1'b0;
      endcase
   end
`else
   logic unused_imm_hi;
   assign range_err     = 1'b0;
   assign unused_imm_hi = ^imm[IMM_W-1:32];
`endif

   assign err = (fmt == FMT_BAD) | range_err;

endmodule

// File: rtl/instr_encode.sv
// Streaming encoder: 1-cycle latency through an output register with one skid slot behind it;
// in_ready is registered (skid empty), so a stalled output absorbs exactly one extra word. IMM_CHECK_EN enables range checks.
module instr_encode
   import instr_encode_pkg::*;
#(
   parameter int XLEN = `XLEN
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [4:0]      in_rd,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [2:0]      in_funct3,
   input  logic [6:0]      in_funct7,
   input  logic [XLEN-1:0] in_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_addr,
   output logic            out_err,
   output logic            err_sticky
);

   fields_t     f;
   logic [31:0] p_instr;
   logic        p_err;
   logic        skid_vld;
   logic [31:0] skid_instr;
   logic        skid_err;
   logic        in_fire;
   logic        out_fire;

   assign f = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                funct3: in_funct3, funct7: in_funct7, imm: IMM_W'($signed(in_imm))};

   instr_pack u_pack (
      .f     (f),
      .instr (p_instr),
      .err   (p_err)
   );

   assign in_ready = ~skid_vld;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         out_valid  <= 1'b0;
         out_instr  <= '0;
         out_err    <= 1'b0;
         out_addr   <= '0;
         err_sticky <= 1'b0;
         skid_vld   <= 1'b0;
         skid_instr <= '0;
         skid_err   <= 1'b0;
      end else begin
         if (out_fire) begin
            out_addr   <= out_addr + XLEN'(4);
            err_sticky <= err_sticky | out_err;
         end
         // Output register is free this cycle: refill from skid first to keep acceptance order.
         if (out_fire || !out_valid) begin
            if (skid_vld) begin
               out_valid <= 1'b1;
               out_instr <= skid_instr;
               out_err   <= skid_err;
               skid_vld  <= 1'b0;
            end else if (in_fire) begin
               out_valid <= 1'b1;
               out_instr <= p_instr;
               out_err   <= p_err;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (in_fire) begin
            skid_vld   <= 1'b1;
            skid_instr <= p_instr;
            skid_err   <= p_err;
         end
      end
   end

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode with a scoreboard queue of expected words and a wrap test on XLEN=12.
module tb_instr_encode;

`ifdef IMM_CHECK_EN
   localparam logic RANGE_ERR = 1'b1;
`else
   localparam logic RANGE_ERR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clear, in_valid, out_ready;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm;
   logic        in_ready, out_valid, out_err, err_sticky;
   logic [31:0] out_instr, out_addr;

   instr_encode #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .out_err(out_err), .err_sticky(err_sticky)
   );

   logic        in_valid12, in_ready12, out_valid12;
   logic [11:0] out_addr12;
   logic [31:0] unused_instr12;
   logic        unused_err12, unused_sticky12;

   instr_encode #(.XLEN(12)) dut12 (
      .clk(clk), .rst(rst), .clear(1'b0),
      .in_valid(in_valid12), .in_ready(in_ready12),
      .in_opcode(7'h13), .in_rd(5'd0), .in_rs1(5'd0), .in_rs2(5'd0),
      .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(12'h000),
      .out_valid(out_valid12), .out_ready(1'b1),
      .out_instr(unused_instr12), .out_addr(out_addr12),
      .out_err(unused_err12), .err_sticky(unused_sticky12)
   );

   typedef struct {
      logic [31:0] instr;
      logic        err;
   } exp_t;

   exp_t        q[$];
   logic [31:0] exp_addr;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n12 = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop on every output handshake, compare word, error flag and address.
   always @(negedge clk) begin
      exp_t e;
      if (rst || clear) begin
         q.delete();
         exp_addr = 32'h0;
      end else if (out_valid && out_ready) begin
         chk("sb_nonempty", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("out_instr", out_instr, e.instr);
            chk("out_err", out_err, e.err);
            chk("out_addr", out_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid12) begin
         if (n12 == 1023) chk("wrap_pre", out_addr12, 12'hFFC);
         if (n12 == 1024) chk("wrap_post", out_addr12, 12'h000);
         n12++;
      end
   end

   task automatic offer(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] ei, input logic ee);
      exp_t e;
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
      e.instr = ei;
      e.err   = ee;
      q.push_back(e);
   endtask

   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] ei, input logic ee);
      offer(op, rd, rs1, rs2, f3, f7, imm, ei, ee);
      wait_accept();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int n;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_valid12 = 1'b0;
      in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_err_sticky", err_sticky, 0);
      @(posedge clk);
      #1;

      send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
      chk("lui_latency", out_valid, 1);
      idle(3);
      do_clear();

      // Back-to-back with unused fields deliberately nonzero.
      c0 = cyc;
      send(7'h13, 5'd1, 5'd0, 5'd9, 3'd0, 7'h55, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
      send(7'h23, 5'd31, 5'd3, 5'd2, 3'd2, 7'h7F, 32'h0000_0008, 32'h0021_A423, 1'b0);
      send(7'h63, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
      send(7'h6F, 5'd1, 5'd4, 5'd4, 3'd7, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
      chk("b2b_cycles", cyc - c0, 4);
      send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0FFF, 32'h4020_81B3, 1'b0);
      send(7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'h0000_0003, 32'h4031_5093, 1'b0);
      send(7'h17, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_1397, 1'b0);
      send(7'h03, 5'd4, 5'd6, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFF83_2203, 1'b0);
      send(7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_8067, 1'b0);
      idle(3);
      do_clear();

      // Output stalled: two accepted, third blocked until release.
      out_ready = 1'b0;
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
      send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0);
      offer(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0193, 1'b0);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold_instr", out_instr, 32'h0010_0093);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_instr2", out_instr, 32'h0010_0093);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_accept();
      idle(4);
      chk("stall_drained", out_valid, 0);
      chk("sticky_clean", err_sticky, 0);

      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, RANGE_ERR);
      idle(3);
      chk("sticky_range", err_sticky, RANGE_ERR);

      send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'h0000_0000, 32'h0000_0013, 1'b1);
      idle(3);
      chk("sticky_bad_op", err_sticky, 1);

      // Clear with a word buffered and another offered in the same cycle.
      out_ready = 1'b0;
      send(7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0, 32'h0010_80B3, 1'b0);
      in_valid = 1'b1;
      do_clear();
      in_valid = 1'b0;
      @(negedge clk);
      chk("clr_out_valid", out_valid, 0);
      chk("clr_err_sticky", err_sticky, 0);
      chk("clr_out_addr", out_addr, 0);
      chk("clr_in_ready", in_ready, 1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      idle(3);
      chk("clr_dropped", out_valid, 0);

      in_valid12 = 1'b1;
      n = 0;
      while (n12 < 1025 && n < 1200) begin
         @(posedge clk);
         n++;
      end
      #1 in_valid12 = 1'b0;
      chk("wrap_count", n12 >= 1025, 1);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
